// File: rtl/jtdd_mcu_pkg.sv
// jtdd_mcu_pkg: shared types and default constants for the main-CPU/sub-MCU interface
package jtdd_mcu_pkg;
   localparam int          SHR_AW        = 9;
   localparam logic [15:0] SHR_BASE_DEF  = 16'h2000;
   localparam logic [15:0] NMI_ADDR_DEF  = 16'h380E;
   localparam logic [15:0] ACK_ADDR_DEF  = 16'h380F;
   localparam logic [15:0] HALT_ADDR_DEF = 16'h380D;
   localparam logic [7:0]  WAIT_MAX_DEF  = 8'd255;

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACC, ST_RD, ST_DONE} st_t;

   function automatic logic win_hit(input logic [15:0] a, input logic [15:0] base);
      return a[15:SHR_AW] == base[15:SHR_AW];
   endfunction
endpackage

// File: rtl/jtdd_mcu_irqlatch.sv
// jtdd_mcu_irqlatch: rising-edge detect on the MCU request with a set-priority clear
module jtdd_mcu_irqlatch (
   input  logic clk,
   input  logic rstn,
   input  logic i_lvl,
   input  logic i_clr,
   output logic o_irq
);
   logic r_prev;
   logic w_rise;

   assign w_rise = i_lvl && !r_prev;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_prev <= 1'b0;
         o_irq  <= 1'b0;
      end else begin
         r_prev <= i_lvl;
         o_irq  <= w_rise ? 1'b1 : i_clr ? 1'b0 : o_irq;
      end
   end
endmodule

// File: rtl/jtdd_mcu_if.sv
// jtdd_mcu_if: main-CPU side of the sub-MCU shared RAM window, NMI/halt control and IRQ latch
module jtdd_mcu_if
   import jtdd_mcu_pkg::*;
#(
   parameter logic [15:0] SHR_BASE  = SHR_BASE_DEF,
   parameter logic [15:0] NMI_ADDR  = NMI_ADDR_DEF,
   parameter logic [15:0] ACK_ADDR  = ACK_ADDR_DEF,
   parameter logic [15:0] HALT_ADDR = HALT_ADDR_DEF,
   parameter logic [7:0]  WAIT_MAX  = WAIT_MAX_DEF
)(
   input  logic        clk,
   input  logic        rstn,
   input  logic        cpu_cen,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rnw,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic        cpu_wait,
   output logic        cpu_irq,
   output logic [8:0]  cpu_AB,
   output logic        cpu_wrn,
   output logic        com_cs,
   input  logic [7:0]  mcu_ram,
   input  logic        mcu_ban,
   output logic        mcu_nmi_set,
   output logic        mcu_haltn,
   input  logic        mcu_irqmain,
   output logic        abort_err
);
   st_t        r_st, w_nx;
   logic       r_rnw, r_nmi_pend;
   logic [7:0] r_cnt;
   logic       w_cen, w_hit, w_reg_wr, w_nmi_wr, w_ack_wr, w_halt_wr, w_nmi_fire, w_to, w_unused;

   assign w_cen      = rstn && cpu_cen && r_st == ST_IDLE;
   assign w_hit      = w_cen && win_hit(cpu_addr, SHR_BASE);
   assign w_reg_wr   = w_cen && !cpu_rnw && !win_hit(cpu_addr, SHR_BASE);
   assign w_nmi_wr   = w_reg_wr && cpu_addr == NMI_ADDR;
   assign w_ack_wr   = w_reg_wr && cpu_addr == ACK_ADDR;
   assign w_halt_wr  = w_reg_wr && cpu_addr == HALT_ADDR;
   assign w_to       = r_st == ST_WAIT && !mcu_ban && r_cnt == WAIT_MAX - 8'd1;
   // a pending request keeps back-to-back NMI writes as separate pulses
   assign w_nmi_fire = !mcu_nmi_set && (w_nmi_wr || r_nmi_pend);
   // write data travels to the RAM straight from cpu_dout; only bit 0 is used here
   assign w_unused   = ^cpu_dout[7:1];

   always_comb begin
      w_nx     = r_st;
      cpu_wait = w_hit;
      com_cs   = 1'b0;
      cpu_wrn  = 1'b1;
      case (r_st)
         ST_IDLE: w_nx = w_hit ? (mcu_ban ? ST_ACC : ST_WAIT) : ST_IDLE;
         ST_WAIT: begin
            cpu_wait = 1'b1;
            w_nx     = mcu_ban ? ST_ACC : w_to ? ST_DONE : ST_WAIT;
         end
         ST_ACC: begin
            cpu_wait = 1'b1;
            com_cs   = 1'b1;
            cpu_wrn  = r_rnw;
            w_nx     = r_rnw ? ST_RD : ST_DONE;
         end
         ST_RD: begin
            cpu_wait = 1'b1;
            w_nx     = ST_DONE;
         end
         default: w_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_st        <= ST_IDLE;
         r_rnw       <= 1'b1;
         r_cnt       <= 8'd0;
         r_nmi_pend  <= 1'b0;
         cpu_AB      <= '0;
         cpu_din     <= 8'hFF;
         mcu_nmi_set <= 1'b0;
         mcu_haltn   <= 1'b0;
         abort_err   <= 1'b0;
      end else begin
         r_st <= w_nx;
         if (w_hit) begin
            cpu_AB <= cpu_addr[SHR_AW-1:0];
            r_rnw  <= cpu_rnw;
         end
         r_cnt <= r_st == ST_WAIT ? r_cnt + 8'd1 : r_st == ST_DONE ? 8'd0 : r_cnt;
         if (r_st == ST_RD) cpu_din <= mcu_ram;
         else if (w_to) cpu_din <= 8'hFF;
         abort_err   <= abort_err || w_to;
         mcu_nmi_set <= w_nmi_fire;
         r_nmi_pend  <= mcu_nmi_set ? (r_nmi_pend || w_nmi_wr) : (r_nmi_pend && w_nmi_wr);
         if (w_halt_wr) mcu_haltn <= cpu_dout[0];
      end
   end

   jtdd_mcu_irqlatch u_irq (
      .clk   (clk),
      .rstn  (rstn),
      .i_lvl (mcu_irqmain),
      .i_clr (w_ack_wr),
      .o_irq (cpu_irq)
   );
endmodule

// File: tb/tb_jtdd_mcu_if.sv
// tb_jtdd_mcu_if: table-driven shared-window checks plus directed NMI/halt/IRQ/reset sequences
module tb_jtdd_mcu_if;
   logic        clk = 1'b0, rstn = 1'b0;
   logic        cpu_cen = 1'b0, cpu_rnw = 1'b1, mcu_ban = 1'b1, mcu_irqmain = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_dout = '0, mcu_ram = '0;
   logic [7:0]  cpu_din;
   logic [8:0]  cpu_AB;
   logic        cpu_wait, cpu_irq, cpu_wrn, com_cs, mcu_nmi_set, mcu_haltn, abort_err;
   int          n_pass = 0, n_tot = 0;

   always #5 clk = ~clk;

   jtdd_mcu_if dut (
      .clk(clk), .rstn(rstn), .cpu_cen(cpu_cen), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw),
      .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_wait(cpu_wait), .cpu_irq(cpu_irq),
      .cpu_AB(cpu_AB), .cpu_wrn(cpu_wrn), .com_cs(com_cs), .mcu_ram(mcu_ram),
      .mcu_ban(mcu_ban), .mcu_nmi_set(mcu_nmi_set), .mcu_haltn(mcu_haltn),
      .mcu_irqmain(mcu_irqmain), .abort_err(abort_err)
   );

   // MCU-side RAM: unwritten locations read as addr[7:0]^8'h3C, 1-clk read latency
   logic [7:0] ram [512];
   bit         wv  [512];

   function automatic logic [7:0] mem(input logic [8:0] a);
      return wv[a] ? ram[a] : (a[7:0] ^ 8'h3C);
   endfunction

   always @(posedge clk) begin
      if (com_cs && !cpu_wrn) begin
         ram[cpu_AB] <= cpu_dout;
         wv[cpu_AB]  <= 1'b1;
      end
      mcu_ram <= mem(cpu_AB);
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", n, act, exp);
   endtask

   task automatic run_acc(input logic [15:0] a, input logic rnw, input logic [7:0] d, input int ban_at,
                          output int nw, output logic [7:0] din, output int ncs, output int nwr,
                          output logic [8:0] ab, output logic done);
      nw = 0; ncs = 0; nwr = 0; ab = '0; din = '0; done = 1'b0;
      @(negedge clk);
      cpu_cen = 1'b1; cpu_addr = a; cpu_rnw = rnw; cpu_dout = d; mcu_ban = ban_at <= 0;
      for (int k = 0; k < 300; k++) begin
         #1;
         if (com_cs) begin
            ncs++;
            ab = cpu_AB;
            if (!cpu_wrn) nwr++;
         end
         if (!cpu_wait) begin
            din  = cpu_din;
            done = 1'b1;
            break;
         end
         nw++;
         @(negedge clk);
         cpu_cen = 1'b0;
         mcu_ban = k + 1 >= ban_at;
      end
      @(negedge clk);
      cpu_cen = 1'b0;
   endtask

   task automatic reg_wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      cpu_cen = 1'b1; cpu_addr = a; cpu_rnw = 1'b0; cpu_dout = d;
      #1 chk("regwr_nowait", cpu_wait, 0);
      @(negedge clk);
      cpu_cen = 1'b0;
      #1;
   endtask

   typedef struct {
      logic [15:0] a;
      logic        rnw;
      logic [7:0]  d;
      int          ban_at;
      int          ew;
      logic        cd;
      logic [7:0]  ed;
      int          ecs;
      int          ewr;
   } vec_t;

   vec_t v [10];

   initial begin
      int nw, ncs, nwr;
      logic [7:0] din;
      logic [8:0] ab;
      logic done;
      v[0] = '{16'h2010, 1'b0, 8'h5A, 0,    2,   1'b0, 8'h00, 1, 1};
      v[1] = '{16'h2010, 1'b1, 8'h00, 0,    3,   1'b1, 8'h5A, 1, 0};
      v[2] = '{16'h21FF, 1'b1, 8'h00, 10,   13,  1'b1, 8'hC3, 1, 0};
      v[3] = '{16'h2155, 1'b0, 8'h96, 3,    5,   1'b0, 8'h00, 1, 1};
      v[4] = '{16'h2155, 1'b1, 8'h00, 0,    3,   1'b1, 8'h96, 1, 0};
      v[5] = '{16'h2033, 1'b1, 8'h00, 0,    3,   1'b1, 8'h0F, 1, 0};
      v[6] = '{16'h1FFF, 1'b1, 8'h00, 0,    0,   1'b0, 8'h00, 0, 0};
      v[7] = '{16'h2200, 1'b0, 8'hAA, 0,    0,   1'b0, 8'h00, 0, 0};
      v[8] = '{16'h2000, 1'b1, 8'h00, 1000, 256, 1'b1, 8'hFF, 0, 0};
      v[9] = '{16'h2020, 1'b0, 8'h11, 1000, 256, 1'b0, 8'h00, 0, 0};

      repeat (3) @(negedge clk);
      #1;
      chk("rst_din", cpu_din, 8'hFF);
      chk("rst_wait", cpu_wait, 0);
      chk("rst_irq", cpu_irq, 0);
      chk("rst_ab", cpu_AB, 0);
      chk("rst_wrn", cpu_wrn, 1);
      chk("rst_cs", com_cs, 0);
      chk("rst_nmi", mcu_nmi_set, 0);
      chk("rst_haltn", mcu_haltn, 0);
      chk("rst_abort", abort_err, 0);
      rstn = 1'b1;

      for (int i = 0; i < 10; i++) begin
         if (i == 8) chk("abort_pre", abort_err, 0);
         run_acc(v[i].a, v[i].rnw, v[i].d, v[i].ban_at, nw, din, ncs, nwr, ab, done);
         chk($sformatf("v%0d_done", i), done, 1);
         chk($sformatf("v%0d_wait", i), nw, v[i].ew);
         chk($sformatf("v%0d_cs", i), ncs, v[i].ecs);
         chk($sformatf("v%0d_wr", i), nwr, v[i].ewr);
         if (v[i].ecs != 0) chk($sformatf("v%0d_ab", i), ab, {23'd0, v[i].a[8:0]});
         if (v[i].cd) chk($sformatf("v%0d_din", i), din, v[i].ed);
      end
      chk("ram_5a", mem(9'h010), 8'h5A);
      chk("ram_96", mem(9'h155), 8'h96);
      chk("ram_dropped", mem(9'h020), 8'h1C);
      chk("abort_set", abort_err, 1);

      reg_wr(16'h380E, 8'h00);
      chk("nmi1_hi", mcu_nmi_set, 1);
      @(negedge clk); #1 chk("nmi1_lo", mcu_nmi_set, 0);
      reg_wr(16'h380E, 8'h00);
      chk("nmi2_hi", mcu_nmi_set, 1);
      @(negedge clk); #1 chk("nmi2_lo", mcu_nmi_set, 0);
      chk("haltn_pre", mcu_haltn, 0);
      reg_wr(16'h380D, 8'h01);
      chk("haltn_set", mcu_haltn, 1);

      @(negedge clk); mcu_irqmain = 1'b1;
      #1 chk("irq_not_yet", cpu_irq, 0);
      @(negedge clk); #1 chk("irq_rise", cpu_irq, 1);
      reg_wr(16'h380F, 8'h00);
      chk("irq_ack", cpu_irq, 0);
      repeat (3) @(negedge clk);
      #1 chk("irq_level_hold", cpu_irq, 0);
      @(negedge clk); mcu_irqmain = 1'b0;
      @(negedge clk);
      mcu_irqmain = 1'b1; cpu_cen = 1'b1; cpu_addr = 16'h380F; cpu_rnw = 1'b0;
      @(negedge clk); cpu_cen = 1'b0;
      #1 chk("irq_set_wins", cpu_irq, 1);
      reg_wr(16'h380F, 8'h00);
      chk("irq_ack2", cpu_irq, 0);

      run_acc(16'h2040, 1'b1, 8'h00, 0, nw, din, ncs, nwr, ab, done);
      chk("abort_sticky", abort_err, 1);

      @(negedge clk);
      cpu_cen = 1'b1; cpu_addr = 16'h2100; cpu_rnw = 1'b1; mcu_ban = 1'b1;
      @(negedge clk); cpu_cen = 1'b0;
      @(negedge clk); #1 chk("rd_busy", cpu_wait, 1);
      #2 rstn = 1'b0;
      #1;
      chk("arst_wait", cpu_wait, 0);
      chk("arst_din", cpu_din, 8'hFF);
      chk("arst_ab", cpu_AB, 0);
      chk("arst_wrn", cpu_wrn, 1);
      chk("arst_cs", com_cs, 0);
      chk("arst_haltn", mcu_haltn, 0);
      chk("arst_abort", abort_err, 0);
      @(negedge clk); rstn = 1'b1;
      run_acc(16'h2000, 1'b0, 8'h77, 0, nw, din, ncs, nwr, ab, done);
      chk("post_rst_wait", nw, 2);
      chk("post_rst_wr", nwr, 1);
      chk("post_rst_ram", mem(9'h000), 8'h77);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
